// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the 8-bit XNOR LFSR byte stream.
// Latency: every output is registered; a sample's effect appears the cycle after its en edge.
// Backpressure: none; the source strobes en and the checker accepts every sampled byte.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   en, din        sample strobe and received generator byte
//   clr_cnt        synchronous clear of err_cnt (wins over a same-edge increment)
//   locked         checker is synchronised to the stream
//   err            one-cycle pulse for a mismatching byte while locked
//   err_cnt        saturating count of err pulses
//   stuck          last sampled byte was 0xFF (LFSR lockup state)
module prbs_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             stuck
);

  // run counts consecutive good predictions in SEEK and consecutive misses in
  // LOCKED, so it only has to hold the larger of the two thresholds.
  localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_CNT - 1);

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       exp_q, exp_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             have_prev_q, have_prev_d;
  logic             err_d;
  logic             stuck_d;
  logic             cnt_inc;

  function automatic logic [7:0] nxt(input logic [7:0] o);
    return {o[6:0], ~(o[2] ^ o[3] ^ o[4] ^ o[6])};
  endfunction

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    have_prev_d = have_prev_q;
    err_d       = 1'b0;
    stuck_d     = stuck;
    cnt_inc     = 1'b0;

    if (en) begin
      stuck_d = (din == 8'hFF);
      case (state_q)
        SEEK: begin
          // Always reseed from the received byte; only the run length decides lock.
          exp_d = nxt(din);
          if (!have_prev_q) begin
            have_prev_d = 1'b1;
            run_d       = '0;
          end else if ((din == exp_q) && (din != 8'hFF)) begin
            if (run_q == LOCK_LAST) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end

        LOCKED: begin
          // Free-run on our own prediction so one bad byte costs one error.
          exp_d = nxt(exp_q);
          if ((din != exp_q) || (din == 8'hFF)) begin
            err_d   = 1'b1;
            cnt_inc = 1'b1;
            if (run_q == UNLOCK_LAST) begin
              state_d     = SEEK;
              have_prev_d = 1'b0;
              run_d       = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end

        default: begin
          state_d     = SEEK;
          have_prev_d = 1'b0;
          run_d       = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEEK;
      exp_q       <= 8'h00;
      run_q       <= '0;
      have_prev_q <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      have_prev_q <= have_prev_d;
      locked      <= (state_d == LOCKED);
      err         <= err_d;
      stuck       <= stuck_d;
    end
  end

  // Clear wins over a simultaneous increment; the count holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (cnt_inc && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int CNT_W      = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [7:0]       din = 8'h00;
  logic             clr_cnt = 1'b0;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic             stuck;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs_checker #(
    .LOCK_CNT(LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .din(din),
    .clr_cnt(clr_cnt),
    .locked(locked),
    .err(err),
    .err_cnt(err_cnt),
    .stuck(stuck)
  );

  // Generator step: shift left, feed in the XNOR of taps 6,4,3,2.
  function automatic logic [7:0] ref_next(input logic [7:0] v);
    return {v[6:0], ~(^(v & 8'h5C))};
  endfunction

  // Reference model: prediction (-1 = none yet), streak lengths, outputs.
  int m_pred, m_good, m_bad, m_locked, m_err, m_cnt, m_stuck;

  task automatic model_reset();
    m_pred = -1; m_good = 0; m_bad = 0;
    m_locked = 0; m_err = 0; m_cnt = 0; m_stuck = 0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] d, input logic c);
    int bad;
    m_err = 0;
    if (e) begin
      m_stuck = (d == 8'hFF) ? 1 : 0;
      if (m_locked == 0) begin
        if (m_pred >= 0 && int'(d) == m_pred && d != 8'hFF) begin
          m_good++;
          if (m_good == LOCK_CNT) begin
            m_locked = 1; m_good = 0; m_bad = 0;
          end
        end else begin
          m_good = 0;
        end
        m_pred = int'(ref_next(d));
      end else begin
        bad = (int'(d) != m_pred || d == 8'hFF) ? 1 : 0;
        m_pred = int'(ref_next(8'(m_pred)));
        if (bad != 0) begin
          m_err = 1;
          m_bad++;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (m_bad == UNLOCK_CNT) begin
            m_locked = 0; m_pred = -1; m_bad = 0; m_good = 0;
          end
        end else begin
          m_bad = 0;
        end
      end
    end
    if (c) m_cnt = 0;
  endtask

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, " locked"},  int'(locked),  m_locked);
    check({tag, " err"},     int'(err),     m_err);
    check({tag, " err_cnt"}, int'(err_cnt), m_cnt);
    check({tag, " stuck"},   int'(stuck),   m_stuck);
  endtask

  // Apply one clock of inputs; sample 1 time unit after the rising edge.
  task automatic cyc(input logic e, input logic [7:0] d, input logic c);
    en = e; din = d; clr_cnt = c;
    @(posedge clk);
    #1;
    model_step(e, d, c);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] din;
    logic       clr;
    logic       locked;
    logic       err;
    int         cnt;
    logic       stuck;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic e, input logic [7:0] d, input logic c,
                              input logic l, input logic er, input int n, input logic s);
    vec_t v;
    v.en = e; v.din = d; v.clr = c; v.locked = l; v.err = er; v.cnt = n; v.stuck = s;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] e8;
    logic [7:0] g;
    logic       re;
    logic       rc;
    logic [7:0] rd;

    // ---------------- table: lock, corruption, unlock, relock, gaps, clear
    //   en  din    clr   locked err cnt stuck
    add(1, 8'h09, 0,    0, 0, 0, 0);
    add(1, 8'h12, 0,    0, 0, 0, 0);
    add(1, 8'h24, 0,    0, 0, 0, 0);
    add(1, 8'h48, 0,    0, 0, 0, 0);
    add(1, 8'h91, 0,    1, 0, 0, 0);   // fourth correct prediction -> lock
    add(1, 8'h22, 0,    1, 0, 0, 0);
    add(1, 8'h00, 0,    1, 1, 1, 0);   // 0x45 corrupted
    add(1, 8'h8B, 0,    1, 0, 1, 0);   // prediction kept running
    add(1, 8'h55, 0,    1, 1, 2, 0);
    add(1, 8'h55, 0,    1, 1, 3, 0);
    add(1, 8'h55, 0,    0, 1, 4, 0);   // third miss drops lock, err still pulses
    add(1, 8'h22, 0,    0, 0, 4, 0);
    add(1, 8'h45, 0,    0, 0, 4, 0);
    add(1, 8'h8B, 0,    0, 0, 4, 0);
    add(1, 8'h16, 0,    0, 0, 4, 0);
    add(1, 8'h2D, 0,    1, 0, 4, 0);   // relocked, count kept
    add(0, 8'h00, 0,    1, 0, 4, 0);   // gap: garbage ignored
    add(1, 8'h5B, 0,    1, 0, 4, 0);
    add(0, 8'h77, 1,    1, 0, 0, 0);   // clear honoured without en
    add(1, 8'h00, 1,    1, 1, 0, 0);   // error and clear on same edge
    add(1, 8'hFF, 0,    1, 1, 1, 1);   // 0xFF is always a miss
    add(1, 8'hDA, 0,    1, 0, 1, 0);   // match resets miss streak

    #2;
    check("reset locked",  int'(locked),  0);
    check("reset err",     int'(err),     0);
    check("reset err_cnt", int'(err_cnt), 0);
    check("reset stuck",   int'(stuck),   0);
    do_reset();

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].din, vecs[i].clr);
      check($sformatf("vec%0d locked", i),  int'(locked),  int'(vecs[i].locked));
      check($sformatf("vec%0d err", i),     int'(err),     int'(vecs[i].err));
      check($sformatf("vec%0d err_cnt", i), int'(err_cnt), vecs[i].cnt);
      check($sformatf("vec%0d stuck", i),   int'(stuck),   int'(vecs[i].stuck));
    end

    // ---------------- lockup: constant 0xFF never locks
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 8'hFF, 1'b0);
      check($sformatf("lockup%0d stuck", k),  int'(stuck),  1);
      check($sformatf("lockup%0d locked", k), int'(locked), 0);
      check($sformatf("lockup%0d err", k),    int'(err),    0);
    end

    // ---------------- async reset while locked with five errors logged
    do_reset();
    cyc(1'b1, 8'h09, 1'b0); cyc(1'b1, 8'h12, 1'b0); cyc(1'b1, 8'h24, 1'b0);
    cyc(1'b1, 8'h48, 1'b0); cyc(1'b1, 8'h91, 1'b0);
    e8 = 8'h22;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 8'h00, 1'b0);
      compare_model($sformatf("midrst err%0d", k));
      e8 = ref_next(e8);
      cyc(1'b1, e8, 1'b0);
      compare_model($sformatf("midrst ok%0d", k));
      e8 = ref_next(e8);
    end
    check("pre-reset err_cnt", int'(err_cnt), 5);
    check("pre-reset locked",  int'(locked),  1);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst locked",  int'(locked),  0);
    check("async rst err",     int'(err),     0);
    check("async rst err_cnt", int'(err_cnt), 0);
    check("async rst stuck",   int'(stuck),   0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 8'h09, 1'b0); cyc(1'b1, 8'h12, 1'b0); cyc(1'b1, 8'h24, 1'b0);
    cyc(1'b1, 8'h48, 1'b0);
    check("relock not yet", int'(locked), 0);
    cyc(1'b1, 8'h91, 1'b0);
    check("relock after 5", int'(locked), 1);
    compare_model("relock");

    // ---------------- randomized stream against the model
    do_reset();
    g = 8'($urandom_range(0, 254));
    for (int k = 0; k < 3000; k++) begin
      re = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 31) == 0);
      rd = 8'($urandom);
      if (re) begin
        rd = g;
        if ($urandom_range(0, 15) == 0) rd = g ^ 8'($urandom_range(1, 255));
        if ($urandom_range(0, 63) == 0) rd = 8'hFF;
        g = ref_next(g);
        if (g == 8'hFF && $urandom_range(0, 7) == 0) g = 8'($urandom_range(0, 254));
      end
      cyc(re, rd, rc);
      compare_model($sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
